// File: rtl/blake2_pkg.sv
// Shared definitions for the BLAKE2 digest path: bus/digest defaults,
// word-count helpers and the unloader FSM state type.
package blake2_pkg;

  localparam int unsigned BUS_WIDTH_DEF    = 32'd64;
  localparam int unsigned DIGEST_WIDTH_DEF = 32'd512;

  function automatic int unsigned words_of(input int unsigned digest_w, input int unsigned bus_w);
    return digest_w / bus_w;
  endfunction

  // A request of zero, or one larger than the digest holds, means the full digest.
  function automatic int unsigned effective_words(input int unsigned req, input int unsigned words);
    return ((req == 32'd0) || (req > words)) ? words : req;
  endfunction

  typedef enum logic [0:0] {
    UNL_IDLE = 1'b0,
    UNL_SEND = 1'b1
  } unl_state_e;

endpackage

// File: rtl/digest_unloader_rise_detect.sv
// Registered rising-edge detector. After reset the input must be seen low
// once before an edge can fire, so a level held across reset is not an event.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise_o
);

  logic dly_q;
  logic arm_q;

  // Delay register plus arm flag that waits for the input to be seen low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      dly_q <= sig_i;
      arm_q <= arm_q | ~sig_i;
    end
  end

  assign rise_o = sig_i & ~dly_q & arm_q;

endmodule

// File: rtl/digest_unloader.sv
// Captures a hash digest on a digest_valid rising edge and streams it out
// word by word over a valid/ready bus, with overrun and flush handling.
module digest_unloader
  import blake2_pkg::*;
#(
  parameter int unsigned BUS_WIDTH    = BUS_WIDTH_DEF,
  parameter int unsigned DIGEST_WIDTH = DIGEST_WIDTH_DEF,
  localparam int unsigned WORDS = words_of(DIGEST_WIDTH, BUS_WIDTH),
  localparam int unsigned CW    = $clog2(WORDS) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    digest_valid,
  input  logic [DIGEST_WIDTH-1:0] digest,
  input  logic [CW-1:0]           out_words,
  output logic [BUS_WIDTH-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clear_overrun,
  input  logic                    flush
);

  unl_state_e              state_q, state_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           n_q, n_d;
  logic [DIGEST_WIDTH-1:0] cap_q, cap_d;
  logic [BUS_WIDTH-1:0]    dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic                    evt_s;
  logic                    xfer_s;
  logic                    ovr_set_s;
  logic [CW-1:0]           n_eff_s;
  logic [CW-1:0]           nxt_idx_s;
  logic [BUS_WIDTH-1:0]    nxt_word_s;

  rise_detect u_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_i   (digest_valid),
    .rise_o  (evt_s)
  );

  assign n_eff_s   = CW'(effective_words(32'(out_words), WORDS));
  assign xfer_s    = valid_q & dout_ready;
  assign nxt_idx_s = idx_q + CW'(1);

  // Select the captured word that follows the one currently presented.
  always_comb begin
    nxt_word_s = '0;
    for (int w = 0; w < int'(WORDS); w++) begin
      nxt_word_s = (nxt_idx_s == CW'(w)) ? cap_q[w*BUS_WIDTH +: BUS_WIDTH] : nxt_word_s;
    end
  end

  // Next-state and registered-output logic for the unload FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    cap_d     = cap_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    ovr_set_s = 1'b0;

    case (state_q)
      UNL_IDLE: begin
        if (evt_s) begin
          state_d = UNL_SEND;
          cap_d   = digest;
          n_d     = n_eff_s;
          idx_d   = '0;
          dout_d  = digest[BUS_WIDTH-1:0];
          valid_d = 1'b1;
          last_d  = (n_eff_s == CW'(1));
          busy_d  = 1'b1;
        end else begin
          state_d = UNL_IDLE;
        end
      end
      UNL_SEND: begin
        if (flush) begin
          state_d = UNL_IDLE;
          idx_d   = '0;
          cap_d   = '0;
          dout_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer_s && last_q) begin
          // A new digest arriving on the final transfer chains straight on.
          if (evt_s) begin
            cap_d   = digest;
            n_d     = n_eff_s;
            idx_d   = '0;
            dout_d  = digest[BUS_WIDTH-1:0];
            valid_d = 1'b1;
            last_d  = (n_eff_s == CW'(1));
            busy_d  = 1'b1;
          end else begin
            state_d = UNL_IDLE;
            idx_d   = '0;
            cap_d   = '0;
            dout_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
          end
        end else if (xfer_s) begin
          idx_d     = nxt_idx_s;
          dout_d    = nxt_word_s;
          last_d    = (nxt_idx_s == (n_q - CW'(1)));
          ovr_set_s = evt_s;
        end else begin
          ovr_set_s = evt_s;
        end
      end
      default: begin
        state_d = UNL_IDLE;
        idx_d   = '0;
        n_d     = '0;
        cap_d   = '0;
        dout_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= UNL_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      cap_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      cap_q     <= cap_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_digest_unloader.sv
// Directed bench for digest_unloader: full and partial unloads, stalls,
// overrun, back-to-back capture, flush and reset mid-unload.
module tb_digest_unloader;

  logic         clk;
  logic         reset_n;
  logic         digest_valid;
  logic [511:0] digest;
  logic [3:0]   out_words;
  logic [63:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         busy;
  logic         overrun;
  logic         clear_overrun;
  logic         flush;

  int checks = 0;
  int errors = 0;

  logic [511:0] d1;
  logic [511:0] d2;

  digest_unloader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .digest_valid  (digest_valid),
    .digest        (digest),
    .out_words     (out_words),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_last     (dout_last),
    .busy          (busy),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] w1(input int i);
    return 64'h1111_1111_1111_1111 * i;
  endfunction

  function automatic logic [63:0] w2(input int i);
    return 64'hDEAD_BEEF_0000_0000 | 64'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; digest_valid = 1'b0; digest = '0; out_words = 4'd0;
    dout_ready = 1'b1; clear_overrun = 1'b0; flush = 1'b0;
    tick(); tick();
    checks++;
    if ({dout, dout_valid, dout_last, busy, overrun} !== 68'd0) begin
      errors++; $display("FAIL reset_outputs: got dout=%h v=%b l=%b b=%b o=%b, need all 0",
                         dout, dout_valid, dout_last, busy, overrun);
    end
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got v=%b b=%b, need 0 0", dout_valid, busy);
    end
  endtask

  task automatic test_full_unload();
    digest = d1; out_words = 4'd0; dout_ready = 1'b1;
    digest_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout !== w1(i) || dout_valid !== 1'b1 || busy !== 1'b1 || dout_last !== (i == 7)) begin
        errors++; $display("FAIL full_word%0d: got dout=%h v=%b b=%b l=%b, need dout=%h v=1 b=1 l=%b",
                           i, dout, dout_valid, busy, dout_last, w1(i), (i == 7));
      end
      tick();
    end
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== 64'd0 || dout_last !== 1'b0) begin
      errors++; $display("FAIL full_end: got dout=%h v=%b b=%b l=%b, need 0", dout, dout_valid, busy, dout_last);
    end
    digest_valid = 1'b0;
    tick();
  endtask

  task automatic test_partial_stall();
    int cnt;
    cnt = 0;
    digest = d1; out_words = 4'd4; dout_ready = 1'b0;
    digest_valid = 1'b1;
    tick();
    out_words = 4'd8;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (dout_valid !== 1'b1) break;
      checks++;
      if (dout !== w1(cnt) || dout_last !== (cnt == 3)) begin
        errors++; $display("FAIL partial_word%0d_cyc%0d: got dout=%h l=%b, need dout=%h l=%b",
                           cnt, cyc, dout, dout_last, w1(cnt), (cnt == 3));
      end
      dout_ready = (cyc % 2 == 1);
      tick();
      if (dout_ready) cnt++;
    end
    checks++;
    if (cnt !== 4 || busy !== 1'b0) begin
      errors++; $display("FAIL partial_count: got %0d words busy=%b, need 4 words busy=0", cnt, busy);
    end
    dout_ready = 1'b1; digest_valid = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    digest = d1; out_words = 4'd0; dout_ready = 1'b1;
    digest_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout !== w1(i) || dout_valid !== 1'b1 || overrun !== (i >= 2)) begin
        errors++; $display("FAIL ovr_word%0d: got dout=%h v=%b o=%b, need dout=%h v=1 o=%b",
                           i, dout, dout_valid, overrun, w1(i), (i >= 2));
      end
      case (i)
        0: digest_valid = 1'b0;
        1: begin digest_valid = 1'b1; digest = d2; end
        3: digest_valid = 1'b0;
        4: begin digest_valid = 1'b1; clear_overrun = 1'b1; end
        5: clear_overrun = 1'b0;
        default: ;
      endcase
      tick();
    end
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_end: got b=%b o=%b, need b=0 o=1", busy, overrun);
    end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got o=%b, need 0", overrun);
    end
    digest_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    digest = d1; out_words = 4'd2; dout_ready = 1'b1;
    digest_valid = 1'b1;
    tick();
    digest_valid = 1'b0;
    tick();
    checks++;
    if (dout !== w1(1) || dout_last !== 1'b1) begin
      errors++; $display("FAIL b2b_first_last: got dout=%h l=%b, need dout=%h l=1", dout, dout_last, w1(1));
    end
    digest_valid = 1'b1; digest = d2; out_words = 4'd0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout !== w2(i) || dout_valid !== 1'b1 || overrun !== 1'b0 || dout_last !== (i == 7)) begin
        errors++; $display("FAIL b2b_word%0d: got dout=%h v=%b o=%b l=%b, need dout=%h v=1 o=0 l=%b",
                           i, dout, dout_valid, overrun, dout_last, w2(i), (i == 7));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got b=%b, need 0", busy);
    end
    digest_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    digest = d1; out_words = 4'd0; dout_ready = 1'b1;
    digest_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (dout !== w1(5)) begin
      errors++; $display("FAIL flush_pre: got dout=%h, need %h", dout, w1(5));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({dout, dout_valid, dout_last, busy, overrun} !== 68'd0) begin
      errors++; $display("FAIL flush_abort: got dout=%h v=%b l=%b b=%b o=%b, need all 0",
                         dout, dout_valid, dout_last, busy, overrun);
    end
    digest_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    digest = d1; out_words = 4'd0; dout_ready = 1'b1;
    digest_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dout, dout_valid, dout_last, busy, overrun} !== 68'd0) begin
      errors++; $display("FAIL rst_mid_async: got dout=%h v=%b l=%b b=%b o=%b, need all 0",
                         dout, dout_valid, dout_last, busy, overrun);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid_hold%0d: got v=%b b=%b, need 0 0", i, dout_valid, busy);
      end
    end
    digest_valid = 1'b0;
    tick();
    digest_valid = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== w1(0)) begin
      errors++; $display("FAIL rst_mid_rearm: got v=%b dout=%h, need v=1 dout=%h", dout_valid, dout, w1(0));
    end
    for (int i = 0; i < 8; i++) tick();
    digest_valid = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      d1[64*i +: 64] = w1(i);
      d2[64*i +: 64] = w2(i);
    end
    test_reset();
    test_full_unload();
    test_partial_stall();
    test_overrun();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

// File: doc/digest_unloader.md
DIGEST_UNLOADER -- requirements
Module: digest_unloader

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, processor bus width in bits.
REQ-002 SHALL have parameter DIGEST_WIDTH, default 512, hash engine digest width; DIGEST_WIDTH SHALL be an integer multiple of BUS_WIDTH; WORDS = DIGEST_WIDTH/BUS_WIDTH (8 by default).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 digest_valid  input  1  level from the hash engine; its rising edge marks a new digest.
REQ-006 digest  input  DIGEST_WIDTH  digest value, valid while digest_valid is high.
REQ-007 out_words  input  $clog2(WORDS)+1  number of words to emit; 0 or >WORDS means WORDS.
REQ-008 dout  output  BUS_WIDTH  digest word presented to the processor.
REQ-009 dout_valid  output  1  dout holds a valid word.
REQ-010 dout_ready  input  1  processor accepts dout this cycle.
REQ-011 dout_last  output  1  current dout word is the final word of the digest.
REQ-012 busy  output  1  a captured digest is still being unloaded.
REQ-013 overrun  output  1  sticky: a digest arrived while busy and was dropped.
REQ-014 clear_overrun  input  1  synchronous clear of overrun.
REQ-015 flush  input  1  synchronous abort of the current unload.

Function
REQ-016 Rising-edge detect: event = digest_valid high at this clock edge and low at the previous edge (one internal delay register).
REQ-017 FSM states IDLE and SEND; all outputs registered.
REQ-018 IDLE + event: latch digest into capture register, latch effective word count N (per REQ-007), word index = 0, go to SEND.
REQ-019 Latency: dout_valid and busy SHALL be high in the cycle immediately after the edge where the event is detected.
REQ-020 Word order: word i = digest[BUS_WIDTH*i +: BUS_WIDTH], word 0 sent first.
REQ-021 Handshake: a transfer occurs when dout_valid && dout_ready; dout, dout_last SHALL remain stable while dout_valid && !dout_ready.
REQ-022 Each transfer increments the index; dout_last high exactly when index == N-1.
REQ-023 Transfer with dout_last: go to IDLE, dout_valid, dout_last, busy low next cycle, unless REQ-025 applies.
REQ-024 Event while busy (SEND, not on the final transfer): new digest dropped, overrun set to 1, current unload continues unchanged.
REQ-025 Event in the same cycle as the final transfer: new digest captured per REQ-018, state stays SEND, no overrun (back-to-back).
REQ-026 overrun stays set until clear_overrun; simultaneous set and clear: set wins.
REQ-027 flush: go to IDLE next cycle, dout_valid/dout_last/busy low; an event in the same cycle as flush is dropped without overrun; flush in IDLE has no effect.
REQ-028 dout SHALL be 0 whenever dout_valid is low; capture register is zeroed on return to IDLE.
REQ-029 out_words is sampled only at capture; later changes have no effect on the unload in progress.

Reset
REQ-030 reset_n low: state IDLE, index 0, capture register 0, edge-detect register 0, dout 0, dout_valid 0, dout_last 0, busy 0, overrun 0.
REQ-031 Reset mid-unload SHALL abort immediately; if digest_valid is still high after release, no event SHALL fire until it goes low and high again.

Structure
REQ-032 Shared package blake2_pkg SHALL hold BUS_WIDTH and DIGEST_WIDTH defaults, the WORDS derivation and the unloader FSM state typedef.
REQ-033 One sub-module, rise_detect (registered rising-edge detector, async active-low reset), SHALL generate the event; datapath and FSM stay in digest_unloader.

Verification
REQ-034 Digest = 0x0123...(word i = 64'h1111_1111_1111_1111*i), out_words=0, dout_ready=1 -> 8 words i=0..7 on consecutive cycles, dout_last on word 7, busy low after.
REQ-035 out_words=4, dout_ready toggling 1/0 -> exactly 4 words, dout stable during stalls, dout_last on word 3.
REQ-036 Second digest_valid rising edge at word 2 -> overrun=1, words 3..7 of the first digest still sent; clear_overrun and a new edge in the same cycle -> overrun stays 1.
REQ-037 New rising edge in the same cycle as the final transfer -> next cycle dout = new word 0, dout_valid high, overrun 0.
REQ-038 flush at word 5 -> dout_valid low next cycle; reset_n pulse at word 3 with digest_valid held high -> all outputs 0, no new unload until digest_valid goes low then high.
